universal_shift_reg: RTL

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 74 +++++++
 1 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a shift counter that pulses frame_done each time WIDTH shifts complete.
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] pin,
  output logic             serial_out,
  output logic [WIDTH-1:0] pout,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             wrap;

  // Counter advance shared by both shift directions, wrapping after WIDTH shifts.
  function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c);
    return (c == LAST_CNT) ? '0 : c + CW'(1);
  endfunction

  assign wrap = (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        unique case (mode)
          MODE_RIGHT: begin
            q    <= {serial_in, q[WIDTH-1:1]};
            cnt  <= next_cnt(cnt);
            done <= wrap;
          end
          MODE_LEFT: begin
            q    <= {q[WIDTH-2:0], serial_in};
            cnt  <= next_cnt(cnt);
            done <= wrap;
          end
          MODE_LOAD: begin
            q   <= pin;
            cnt <= '0;
          end
          MODE_HOLD: ;
          default: ;
        endcase
      end
    end
  end

  // The leaving bit depends on the direction currently selected, not the last one used.
  assign serial_out = (mode == MODE_LEFT) ? q[WIDTH-1] : q[0];
  assign pout       = q;
  assign shift_cnt  = cnt;
  assign frame_done = done;

endmodule
